// File: rtl/risc_isa_pkg.sv
// Shared ISA constants for the multicycle RISC controller: major/minor opcode
// encodings and the step numbers that end each instruction class.
package risc_isa_pkg;

    localparam logic [4:0] OP_ALU       = 5'b00000;
    localparam logic [4:0] OP_LHI       = 5'b00001;
    localparam logic [4:0] OP_LLI       = 5'b00010;
    localparam logic [4:0] OP_LDRRI     = 5'b00011;
    localparam logic [4:0] OP_LDRRR     = 5'b00100;
    localparam logic [4:0] OP_STRRI     = 5'b00101;
    localparam logic [4:0] OP_STRRR_CMP = 5'b00110;
    localparam logic [4:0] OP_ADDI      = 5'b00111;
    localparam logic [4:0] OP_SUBI      = 5'b01000;
    localparam logic [4:0] OP_MOV       = 5'b01011;
    localparam logic [4:0] OP_JMP       = 5'b10000;
    localparam logic [4:0] OP_JALRL     = 5'b10001;
    localparam logic [4:0] OP_JALRR     = 5'b10010;
    localparam logic [4:0] OP_JR        = 5'b10011;
    localparam logic [4:0] OP_BCOND     = 5'b11000;
    localparam logic [4:0] OP_BAL       = 5'b11001;
    localparam logic [4:0] OP_SYS       = 5'b11100;

    localparam logic [1:0] SYS_OUTR = 2'b00;
    localparam logic [1:0] SYS_HLT  = 2'b01;
    localparam logic [1:0] CMP_L    = 2'b01;

    localparam logic [2:0] STEP_SHORT = 3'd2;
    localparam logic [2:0] STEP_MID   = 3'd3;
    localparam logic [2:0] STEP_LONG  = 3'd4;
    localparam logic [2:0] STEP_MAX   = 3'd7;

endpackage

// File: rtl/signal_done.sv
// Halt decoder: Done is high only for SYS/HLT outside reset.
// Latency: combinational, zero cycles. Backpressure: none.
module signal_done
    import risc_isa_pkg::*;
(
    input  logic       Rst,
    input  logic [4:0] InsM,
    input  logic [1:0] InsL,
    output logic       Done
);

    // Unknown opcode bits make the condition false, so Done stays low.
    always_comb begin
        Done = 1'b0;
        if (!Rst && InsM == OP_SYS && InsL == SYS_HLT) begin
            Done = 1'b1;
        end
    end

endmodule

// File: rtl/signal_buff_pc.sv
// Instruction step sequencer: owns Cnt, flags the final step (Buff_PC) and halt (Done).
// Latency: Buff_PC/Done combinational; Cnt updates each clk. Backpressure: none.
module signal_buff_pc
    import risc_isa_pkg::*;
(
    input  logic       clk,
    input  logic       Rst,
    input  logic [4:0] InsM,
    input  logic [1:0] InsL,
    output logic [2:0] Cnt,
    output logic       Buff_PC,
    output logic       Done
);

    logic [2:0] last_step;

    // Undefined (or unknown) encodings fall to default and behave as a NOP.
    always_comb begin
        last_step = STEP_SHORT;
        case (InsM)
            OP_LHI, OP_LLI, OP_MOV:        last_step = STEP_SHORT;
            OP_ALU, OP_ADDI, OP_SUBI:      last_step = STEP_MID;
            OP_STRRR_CMP, OP_STRRI:        last_step = STEP_MID;
            OP_LDRRI, OP_LDRRR:            last_step = STEP_LONG;
            OP_BCOND, OP_BAL:              last_step = STEP_SHORT;
            OP_JMP, OP_JR:                 last_step = STEP_SHORT;
            OP_JALRL, OP_JALRR:            last_step = STEP_MID;
            OP_SYS:                        last_step = STEP_SHORT;
            default:                       last_step = STEP_SHORT;
        endcase
    end

    // STEP_MAX term keeps the counter from wrapping when the opcode changes late.
    always_comb begin
        Buff_PC = 1'b0;
        if (!Rst && (Cnt == last_step || Cnt == STEP_MAX)) begin
            Buff_PC = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst || Buff_PC) begin
            Cnt <= 3'd0;
        end else begin
            Cnt <= Cnt + 3'd1;
        end
    end

    signal_done u_signal_done (
        .Rst  (Rst),
        .InsM (InsM),
        .InsL (InsL),
        .Done (Done)
    );

endmodule

// File: tb/tb_signal_buff_pc.sv
// Scoreboard bench for signal_buff_pc: driver queues per-cycle expectations,
// monitor compares Cnt/Buff_PC/Done on the falling edge.
module tb_signal_buff_pc;

    logic       clk;
    logic       Rst;
    logic [4:0] InsM;
    logic [1:0] InsL;
    logic [2:0] Cnt;
    logic       Buff_PC;
    logic       Done;

    signal_buff_pc dut (
        .clk     (clk),
        .Rst     (Rst),
        .InsM    (InsM),
        .InsL    (InsL),
        .Cnt     (Cnt),
        .Buff_PC (Buff_PC),
        .Done    (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] cnt;
        logic       buff;
        logic       done;
        string      nm;
    } exp_t;

    typedef struct {
        logic [4:0] m;
        logic [1:0] l;
        int         last;
        bit         dn;
        string      nm;
    } vec_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   passes = 0;

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (Cnt === e.cnt && Buff_PC === e.buff && Done === e.done) begin
                passes++;
            end else begin
                $display("FAIL %s: got Cnt=%0d Buff_PC=%b Done=%b, expected Cnt=%0d Buff_PC=%b Done=%b",
                         e.nm, Cnt, Buff_PC, Done, e.cnt, e.buff, e.done);
            end
        end
    end

    task automatic push(input int c, input bit b, input bit d, input string nm);
        exp_t x;
        x.cnt  = c[2:0];
        x.buff = b;
        x.done = d;
        x.nm   = nm;
        q.push_back(x);
    endtask

    // Cnt=0 cycle carries a NOP filler; the opcode under test is loaded at Cnt=1.
    task automatic run_instr(input logic [4:0] m, input logic [1:0] l,
                             input int last, input bit dn, input string nm);
        @(posedge clk); #1;
        Rst = 1'b0; InsM = 5'b11111; InsL = 2'b00;
        push(0, 1'b0, 1'b0, {nm, "/c0"});
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            InsM = m; InsL = l;
            push(c, c == last, dn, $sformatf("%s/c%0d", nm, c));
        end
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{5'b00001, 2'b00, 2, 1'b0, "LHI"},
            '{5'b00010, 2'b00, 2, 1'b0, "LLI"},
            '{5'b01011, 2'b00, 2, 1'b0, "MOV"},
            '{5'b00000, 2'b10, 3, 1'b0, "SUB"},
            '{5'b00000, 2'b11, 3, 1'b0, "SBB"},
            '{5'b00111, 2'b00, 3, 1'b0, "ADDI"},
            '{5'b01000, 2'b00, 3, 1'b0, "SUBI"},
            '{5'b00110, 2'b01, 3, 1'b0, "CMP"},
            '{5'b00110, 2'b00, 3, 1'b0, "STRrr"},
            '{5'b00011, 2'b00, 4, 1'b0, "LDRri"},
            '{5'b00100, 2'b00, 4, 1'b0, "LDRrr"},
            '{5'b00101, 2'b00, 3, 1'b0, "STRri"},
            '{5'b11000, 2'b00, 2, 1'b0, "BCC"},
            '{5'b11001, 2'b00, 2, 1'b0, "BAL"},
            '{5'b10000, 2'b00, 2, 1'b0, "JMP"},
            '{5'b10011, 2'b00, 2, 1'b0, "JR"},
            '{5'b10001, 2'b00, 3, 1'b0, "JALrl"},
            '{5'b10010, 2'b00, 3, 1'b0, "JALrr"},
            '{5'b11100, 2'b00, 2, 1'b0, "OutR"},
            '{5'b11100, 2'b01, 2, 1'b1, "HLT"},
            '{5'b11111, 2'b00, 2, 1'b0, "UNDEF"},
            '{5'b00000, 2'b00, 3, 1'b0, "ADD"}
        };
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] xm;
        logic [1:0] xl;
        int         xlast;
        bit         xdn;

        Rst = 1'b1; InsM = 5'b11100; InsL = 2'b01;

        // Reset held 3 clocks with HLT on the bus: everything stays low.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            Rst = 1'b1; InsM = 5'b11100; InsL = 2'b01;
            push(0, 1'b0, 1'b0, $sformatf("reset%0d", i));
        end

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            run_instr(vecs[i].m, vecs[i].l, vecs[i].last, vecs[i].dn, vecs[i].nm);
        end

        // Unknown opcode bits: decode as a NOP unless the simulator resolves them.
        xm = 'x; xl = 'x;
        xlast = 2; xdn = 1'b0;
        if (!$isunknown(xm) && !$isunknown(xl)) begin
            for (int i = 0; i < vecs.size(); i++) begin
                if (vecs[i].m == xm && (vecs[i].m != 5'b11100 || vecs[i].l == xl)) begin
                    xlast = vecs[i].last;
                end
            end
            xdn = (xm == 5'b11100 && xl == 2'b01);
        end
        run_instr(xm, xl, xlast, xdn, "XOP");

        // Reset pulsed at Cnt=3 of LDR.
        @(posedge clk); #1;
        Rst = 1'b0; InsM = 5'b11111; InsL = 2'b00;
        push(0, 1'b0, 1'b0, "rstldr/c0");
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            InsM = 5'b00011; InsL = 2'b00;
            push(c, 1'b0, 1'b0, $sformatf("rstldr/c%0d", c));
        end
        @(posedge clk); #1;
        Rst = 1'b1;
        push(3, 1'b0, 1'b0, "rstldr/c3_rst");

        // LDR switched to LHI at Cnt=4: past its last step, runs to 7.
        @(posedge clk); #1;
        Rst = 1'b0; InsM = 5'b11111; InsL = 2'b00;
        push(0, 1'b0, 1'b0, "runaway/c0");
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            InsM = 5'b00011;
            push(c, 1'b0, 1'b0, $sformatf("runaway/c%0d", c));
        end
        for (int c = 4; c <= 7; c++) begin
            @(posedge clk); #1;
            InsM = 5'b00001;
            push(c, c == 7, 1'b0, $sformatf("runaway/c%0d", c));
        end

        // Wrap after the safety-net step.
        @(posedge clk); #1;
        InsM = 5'b11111;
        push(0, 1'b0, 1'b0, "runaway/wrap");

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() == 0) begin
            passes++;
        end else begin
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/signal_buff_pc.md
# signal_buff_pc

Instruction step sequencer for the multicycle RISC controller. It owns the 3-bit step counter `Cnt`, decodes the current instruction's major opcode `InsM` and minor opcode `InsL`, and asserts `Buff_PC` on the final step of each instruction so the next instruction starts. It also raises `Done` when a halt instruction is decoded. It sits beside the main controller FSM, which latches `InsM`/`InsL` when `Cnt == 1`.

## Interface
- Parameters: none. Constants come from the shared package.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `InsM`  in  5 (`[15:11]`)  major opcode field of the current instruction.
- `InsL`  in  2 (`[1:0]`)  minor opcode field; a don't-care for most opcodes.
- `Cnt`  out  3  current step number (0 = fetch, 1 = decode, 2 and up = execute).
- `Buff_PC`  out  1  last-step flag; combinational.
- `Done`  out  1  halt flag; combinational.

## Operation
- Counter update on each rising `clk`:
  - `Rst == 1` or `Buff_PC == 1`: `Cnt <= 0`.
  - Otherwise `Cnt <= Cnt + 1`.
- `Buff_PC = !Rst && (Cnt == last_step(InsM, InsL) || Cnt == 7)`. The `Cnt == 7` term is a safety net so the counter never wraps silently.
- `last_step` decode:
  - `InsM = 00001` LHI: 2
  - `00010` LLI: 2
  - `01011` MOV: 2
  - `00000` ADD/ADC/SUB/SBB (any `InsL`): 3
  - `00111` ADDI: 3
  - `01000` SUBI: 3
  - `00110` with `InsL = 01` CMP: 3
  - `00011` LDRri: 4
  - `00100` LDRrr: 4
  - `00101` STRri: 3
  - `00110` with `InsL != 01` STRrr: 3
  - `11000` BCC/BCS/BEQ/BNE: 2
  - `11001` BAL: 2
  - `10000` JMP: 2
  - `10011` JR: 2
  - `10001` JALrl: 3
  - `10010` JALrr: 3
  - `11100` OutR (`InsL = 00`) and HLT (`InsL = 01`): 2
  - Any other encoding, including X or Z on `InsM`/`InsL`: 2. Undefined opcodes behave as a NOP and never stall the sequencer.
- `Done = !Rst && InsM == 11100 && InsL == 01`. No other encoding asserts `Done`.
- `Buff_PC` also fires normally for HLT. Freezing the PC on halt is the controller's job, done by watching `Done`.

## Timing
- Reset values: `Cnt = 0`, `Buff_PC = 0`, `Done = 0`, while `Rst` is high and on the first edge after it is released.
- `Buff_PC` and `Done` are purely combinational from the current `Cnt`, `InsM`, `InsL` and `Rst`, with zero latency.
- Instruction length is `last_step + 1` clocks. Example: LDR occupies `Cnt` values 0..4, with `Buff_PC` high during `Cnt = 4`, and the next edge loads `Cnt = 0`.
- `Rst` asserted mid-instruction takes priority: `Buff_PC` drops immediately and `Cnt = 0` after the next edge.
- If `InsM`/`InsL` change mid-instruction, the new decode applies from that cycle on.
  - If `Cnt` is already beyond the new `last_step`, counting continues until `Cnt == 7` forces `Buff_PC`.

## Structure
- Shared package `risc_isa_pkg` holds:
  - 5-bit major-opcode constants (`OP_ALU`, `OP_LHI`, `OP_LLI`, `OP_LDRRI`, `OP_LDRRR`, `OP_STRRI`, `OP_STRRR_CMP`, `OP_ADDI`, `OP_SUBI`, `OP_MOV`, `OP_BCOND`, `OP_BAL`, `OP_JMP`, `OP_JALRL`, `OP_JALRR`, `OP_JR`, `OP_SYS`).
  - Minor codes `SYS_OUTR = 2'b00`, `SYS_HLT = 2'b01`, `CMP_L = 2'b01`.
  - 3-bit step constants `STEP_SHORT = 2`, `STEP_MID = 3`, `STEP_LONG = 4`.
- Sub-module `signal_done` holds the combinational halt decoder (inputs `Rst`, `InsM`, `InsL`; output `Done`). The counter and the `last_step` decode stay in the top module.

## Test plan
- Reset: hold `Rst = 1` for 3 clocks with any opcode -> `Cnt = 0`, `Buff_PC = 0`, `Done = 0` throughout.
- Sweep every opcode, loading each at `Cnt = 1` after release:
  - `Buff_PC` is high at `Cnt = 2` for LHI, LLI, MOV, branches, JMP, JR, OutR and HLT.
  - `Buff_PC` is high at `Cnt = 3` for the ALU group, ADDI, SUBI, CMP, STR and JAL.
  - `Buff_PC` is high at `Cnt = 4` for LDR.
  - On each of these, the following edge gives `Cnt = 0`.
- HLT (`InsM = 11100`, `InsL = 01`) -> `Done = 1`; OutR (`InsL = 00`) -> `Done = 0`; ADD -> `Done = 0`; HLT with `Rst = 1` -> `Done = 0`.
- `InsM = 00110`: with `InsL = 01` (CMP) `Buff_PC` fires at `Cnt = 3`; with `InsL = 00` (STRrr) it also fires at `Cnt = 3`, and `Done` stays 0 in both cases.
- Undefined opcode `InsM = 11111`, and all-X `InsM`/`InsL` -> `Buff_PC` at `Cnt = 2`; the sequencer does not hang.
- `Rst` pulsed while LDR is at `Cnt = 3` -> `Buff_PC = 0` in that cycle, then `Cnt = 0` on the next edge.
